// File: rtl/seq_tx.sv
// Burst serial pattern transmitter: shifts a latched PW-bit pattern out MSB first,
// repeats it with optional idle gaps, and counts detector hits over the burst.
module seq_tx #(
  parameter int unsigned PW = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          start,
  input  logic [PW-1:0] pattern,
  input  logic [3:0]    repeats,  // frames minus one; `repeat` is a reserved word
  input  logic [2:0]    gap,
  input  logic          z,
  output logic          w,
  output logic          valid,
  output logic          busy,
  output logic          done,
  output logic [3:0]    frame_cnt,
  output logic [3:0]    hit_count
);

  localparam int unsigned IW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [IW-1:0] IdxMax = IW'(PW - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e        state_q;
  logic [PW-1:0] pat_q;
  logic [3:0]    rep_q;
  logic [2:0]    gap_q;
  logic [2:0]    gap_cnt_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_dec;
  logic [3:0]    frame_q;
  logic [3:0]    hit_q;
  logic          w_q;
  logic          valid_q;
  logic          busy_q;
  logic          done_q;

  assign idx_dec = idx_q - 1'b1;

  // Outputs are registered: each branch computes what w/valid should show in
  // the state being entered, so the first bit appears the cycle after start.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= StIdle;
      pat_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      idx_q     <= IdxMax;
      frame_q   <= '0;
      hit_q     <= '0;
      w_q       <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      w_q     <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;

      if ((state_q != StIdle) && z && (hit_q != 4'd15)) begin
        hit_q <= hit_q + 4'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            pat_q   <= pattern;
            rep_q   <= repeats;
            gap_q   <= gap;
            frame_q <= '0;
            hit_q   <= '0;
            idx_q   <= IdxMax;
            state_q <= StSend;
            busy_q  <= 1'b1;
            w_q     <= pattern[IdxMax];
            valid_q <= 1'b1;
          end
        end

        StSend: begin
          if (idx_q == '0) begin
            frame_q <= frame_q + 4'd1;
            if (rep_q == '0) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              rep_q <= rep_q - 4'd1;
              if (gap_q != '0) begin
                state_q   <= StGap;
                gap_cnt_q <= gap_q;
              end else begin
                idx_q   <= IdxMax;
                w_q     <= pat_q[IdxMax];
                valid_q <= 1'b1;
              end
            end
          end else begin
            idx_q   <= idx_dec;
            w_q     <= pat_q[idx_dec];
            valid_q <= 1'b1;
          end
        end

        StGap: begin
          if (gap_cnt_q == 3'd1) begin
            gap_cnt_q <= '0;
            state_q   <= StSend;
            idx_q     <= IdxMax;
            w_q       <= pat_q[IdxMax];
            valid_q   <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - 3'd1;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign w         = w_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_q;
  assign hit_count = hit_q;

endmodule

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx with a looped-back overlapping 1101 detector model.
module tb_seq_tx;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] repeats;
  logic [2:0] gap;
  logic       z;
  logic       w;
  logic       valid;
  logic       busy;
  logic       done;
  logic [3:0] frame_cnt;
  logic [3:0] hit_count;

  logic [2:0] hist;
  logic       z_force;

  int asserts  = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  // Mealy 1101 detector fed by w; z_force lets tests inject detections directly
  always @(posedge Clock) hist <= Reset ? 3'b000 : {hist[1:0], w};
  assign z = z_force | ({hist, w} == 4'b1101);

  seq_tx #(.PW(4)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .start     (start),
    .pattern   (pattern),
    .repeats   (repeats),
    .gap       (gap),
    .z         (z),
    .w         (w),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt),
    .hit_count (hit_count)
  );

  task automatic test_reset();
    Reset = 1'b1; start = 1'b0; pattern = 4'b1111; repeats = 4'd3; gap = 3'd1; z_force = 1'b1;
    repeat (2) @(negedge Clock);
    asserts++;
    if ({w, valid, busy, done} !== 4'b0000) begin
      failures++; $display("FAIL reset_outputs: got %b want 0000", {w, valid, busy, done});
    end
    asserts++;
    if (frame_cnt !== 4'd0) begin
      failures++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
    end
    asserts++;
    if (hit_count !== 4'd0) begin
      failures++; $display("FAIL reset_hit_count: got %0d want 0", hit_count);
    end
    Reset = 1'b0; z_force = 1'b0;
  endtask

  // pattern 1101, one frame, no gap
  task automatic test_single();
    logic [3:0] exp_v [6] = '{4'b1110, 4'b1110, 4'b0110, 4'b1110, 4'b0001, 4'b0000};
    start = 1'b1; pattern = 4'b1101; repeats = 4'd0; gap = 3'd0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clock);
      if (c == 1) start = 1'b0;
      asserts++;
      if ({w, valid, busy, done} !== exp_v[c-1]) begin
        failures++;
        $display("FAIL single_wvbd c%0d: got %b want %b", c, {w, valid, busy, done}, exp_v[c-1]);
      end
      if (c == 4) begin
        asserts++;
        if (z !== 1'b1) begin failures++; $display("FAIL single_z c4: got %b want 1", z); end
        asserts++;
        if (hit_count !== 4'd0) begin
          failures++; $display("FAIL single_hit c4: got %0d want 0", hit_count);
        end
      end
    end
    asserts++;
    if (frame_cnt !== 4'd1) begin failures++; $display("FAIL single_frame: got %0d want 1", frame_cnt); end
    asserts++;
    if (hit_count !== 4'd1) begin failures++; $display("FAIL single_hit: got %0d want 1", hit_count); end
  endtask

  // pattern 1101, three frames, two-cycle gaps
  task automatic test_gap();
    logic [3:0] pat = 4'b1101;
    logic [3:0] e;
    int p;
    int ef;
    start = 1'b1; pattern = pat; repeats = 4'd2; gap = 3'd2;
    for (int c = 1; c <= 18; c++) begin
      @(negedge Clock);
      if (c == 1) start = 1'b0;
      if (c <= 16) begin
        p = (c - 1) % 6;
        e = (p < 4) ? {pat[3-p], 3'b110} : 4'b0010;
      end else begin
        e = (c == 17) ? 4'b0001 : 4'b0000;
      end
      ef = (c > 4 ? 1 : 0) + (c > 10 ? 1 : 0) + (c > 16 ? 1 : 0);
      asserts++;
      if ({w, valid, busy, done} !== e) begin
        failures++; $display("FAIL gap_wvbd c%0d: got %b want %b", c, {w, valid, busy, done}, e);
      end
      asserts++;
      if (frame_cnt !== 4'(ef)) begin
        failures++; $display("FAIL gap_frame c%0d: got %0d want %0d", c, frame_cnt, ef);
      end
    end
    asserts++;
    if (hit_count !== 4'd3) begin failures++; $display("FAIL gap_hit: got %0d want 3", hit_count); end
  endtask

  // Counters hold in IDLE and z is ignored there
  task automatic test_hold_counters();
    z_force = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      asserts++;
      if ({frame_cnt, hit_count, busy} !== {4'd3, 4'd3, 1'b0}) begin
        failures++;
        $display("FAIL hold_idle c%0d: got frame=%0d hit=%0d busy=%b want 3 3 0",
                 c, frame_cnt, hit_count, busy);
      end
    end
    z_force = 1'b0;
  endtask

  // start held high: one burst, no relatch, restart right after DONE->IDLE
  task automatic test_start_held();
    logic [3:0] e;
    start = 1'b1; pattern = 4'b1101; repeats = 4'd0; gap = 3'd0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clock);
      if (c == 2) pattern = 4'b0010;
      if (c == 7) start = 1'b0;
      unique case (c)
        1, 2, 4: e = 4'b1110;
        3:       e = 4'b0110;
        5, 11:   e = 4'b0001;
        6, 12:   e = 4'b0000;
        9:       e = 4'b1110;
        default: e = 4'b0110;
      endcase
      asserts++;
      if ({w, valid, busy, done} !== e) begin
        failures++; $display("FAIL held_wvbd c%0d: got %b want %b", c, {w, valid, busy, done}, e);
      end
      if (c == 6 || c == 7) begin
        asserts++;
        if (hit_count !== ((c == 6) ? 4'd1 : 4'd0)) begin
          failures++; $display("FAIL held_hit c%0d: got %0d", c, hit_count);
        end
      end
    end
    asserts++;
    if (frame_cnt !== 4'd1) begin failures++; $display("FAIL held_frame: got %0d want 1", frame_cnt); end
  endtask

  // Reset in cycle 3 aborts; reset beats start and z; no done pulse follows
  task automatic test_reset_mid();
    start = 1'b1; pattern = 4'b1101; repeats = 4'd2; gap = 3'd1; z_force = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge Clock);
      if (c == 1) start = 1'b0;
      if (c == 3) begin
        asserts++;
        if ({busy, hit_count} !== {1'b1, 4'd2}) begin
          failures++; $display("FAIL rst_mid_pre: got busy=%b hit=%0d want 1 2", busy, hit_count);
        end
        z_force = 1'b0; Reset = 1'b1;
      end
      if (c == 4 || c == 5) begin
        asserts++;
        if ({w, valid, busy, done, frame_cnt, hit_count} !== 12'h0) begin
          failures++;
          $display("FAIL rst_mid_idle c%0d: got w=%b v=%b b=%b d=%b f=%0d h=%0d want all 0",
                   c, w, valid, busy, done, frame_cnt, hit_count);
        end
      end
      if (c == 4) begin start = 1'b1; z_force = 1'b1; end
      if (c == 5) begin Reset = 1'b0; start = 1'b0; z_force = 1'b0; end
      if (c >= 6) begin
        asserts++;
        if ({busy, done} !== 2'b00) begin
          failures++; $display("FAIL rst_mid_nodone c%0d: got busy=%b done=%b want 0 0", c, busy, done);
        end
      end
    end
  endtask

  // 16 back-to-back frames: hit saturates at 15, frame_cnt wraps to 0
  task automatic test_long();
    logic [3:0] pat = 4'b1101;
    logic [3:0] e;
    int eh;
    start = 1'b1; pattern = pat; repeats = 4'd15; gap = 3'd0;
    for (int c = 1; c <= 66; c++) begin
      @(negedge Clock);
      if (c == 1) start = 1'b0;
      if (c <= 64)      e = {pat[3 - ((c - 1) % 4)], 3'b110};
      else if (c == 65) e = 4'b0001;
      else              e = 4'b0000;
      eh = ((c - 1) / 4 > 15) ? 15 : (c - 1) / 4;
      asserts++;
      if ({w, valid, busy, done} !== e) begin
        failures++; $display("FAIL long_wvbd c%0d: got %b want %b", c, {w, valid, busy, done}, e);
      end
      asserts++;
      if (frame_cnt !== 4'(((c - 1) / 4) % 16)) begin
        failures++; $display("FAIL long_frame c%0d: got %0d want %0d", c, frame_cnt, ((c - 1) / 4) % 16);
      end
      asserts++;
      if (hit_count !== 4'(eh)) begin
        failures++; $display("FAIL long_hit c%0d: got %0d want %0d", c, hit_count, eh);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_hold_counters();
    test_start_held();
    test_reset_mid();
    test_long();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
